// File: rtl/spi_slave_fifo_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the SPI target controller.
package spi_slave_fifo_ctrl_pkg;

  localparam int   DEF_CHAR_NBITS = 8;
  localparam int   DEF_FIFO_DEPTH = 8;
  localparam logic DEF_FILL_BIT   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_slave_fifo_ctrl_fifo.sv
// Synchronous FIFO with occupancy count, full/empty flags and a flush input.
// Push while full is dropped; simultaneous push and pop both take effect.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  // Head reads as zero when empty so the output is defined straight out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_fifo_ctrl.sv
// SPI target controller: oversampled SCK/MOSI/CS, all CPOL/CPHA modes, variable character
// length, TX/RX FIFOs and sticky error flags. FSM state is visible on S_DBG_STATE.
module spi_slave_fifo_ctrl
  import spi_slave_fifo_ctrl_pkg::*;
#(
  parameter int                    CHAR_NBITS    = DEF_CHAR_NBITS,
  parameter int                    FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter logic [CHAR_NBITS-1:0] UNDERRUN_FILL = {CHAR_NBITS{DEF_FILL_BIT}}
) (
  input  logic                              S_SYSCLK,
  input  logic                              S_RESETN,
  input  logic                              S_ENABLE,
  input  logic                              S_CPOL,
  input  logic                              S_CPHA,
  input  logic                              S_CSPOL,
  input  logic                              S_REV,
  input  logic [$clog2(CHAR_NBITS)-1:0]     S_CHAR_LEN,
  input  logic                              S_SPI_CS,
  input  logic                              S_SPI_SCK,
  input  logic                              S_SPI_MOSI,
  output logic                              S_SPI_MISO,
  output logic                              S_SPI_MISO_OE,
  input  logic [CHAR_NBITS-1:0]             S_TX_DATA,
  input  logic                              S_TX_VALID,
  output logic                              S_TX_READY,
  output logic [CHAR_NBITS-1:0]             S_RX_DATA,
  output logic                              S_RX_VALID,
  input  logic                              S_RX_READY,
  output logic [$clog2(FIFO_DEPTH):0]       S_TX_CNT,
  output logic [$clog2(FIFO_DEPTH):0]       S_RX_CNT,
  input  logic                              S_ERR_CLR,
  output logic                              S_RX_OVF,
  output logic                              S_TX_UNF,
  output logic                              S_FRAME_DONE,
  output logic [1:0]                        S_DBG_STATE
);

  localparam int LW = $clog2(CHAR_NBITS);

  // Handshakes: a character moves on a rising S_SYSCLK where valid and ready are both 1;
  // valid never waits for ready, and ready (TX not full) never depends on valid.

  logic [2:0]            sck_sync;
  logic [2:0]            cs_sync;
  logic [1:0]            mosi_sync;
  logic                  sck_rise, sck_fall, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge;
  logic                  cs_act, cs_act_d, cs_start, mosi_bit;
  spi_state_t            state_q, state_d;
  logic                  load_go, tx_pop, rx_push, frame_done_d;
  logic [CHAR_NBITS-1:0] tx_head, rx_head, tx_word, tx_sr, tx_shifted, rx_sr, rx_next;
  logic [LW-1:0]         bit_cnt, len_q, rx_pos;
  logic                  rev_q, shift_pending, miso_q, miso_oe_q;
  logic                  frame_done_q, rx_ovf_q, tx_unf_q;
  logic                  tx_full, tx_empty, rx_full, rx_empty;

  // MOSI needs no edge detect, so its 2-flop output lines up with the SCK edge decode.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], S_SPI_SCK};
      cs_sync   <= {cs_sync[1:0], S_SPI_CS};
      mosi_sync <= {mosi_sync[0], S_SPI_MOSI};
    end
  end

  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign lead_edge   = S_CPOL ? sck_fall : sck_rise;
  assign trail_edge  = S_CPOL ? sck_rise : sck_fall;
  assign sample_edge = S_CPHA ? trail_edge : lead_edge;
  assign shift_edge  = S_CPHA ? lead_edge : trail_edge;
  assign cs_act      = S_CSPOL ? ~cs_sync[1] : cs_sync[1];
  assign cs_act_d    = S_CSPOL ? ~cs_sync[2] : cs_sync[2];
  // Start on an assertion edge so the reset value of the synchronizer cannot open a frame.
  assign cs_start    = cs_act & ~cs_act_d;
  assign mosi_bit    = mosi_sync[1];

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    rx_push      = 1'b0;
    frame_done_d = 1'b0;
    if (!S_ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_start) state_d = ST_LOAD;
        end
        ST_LOAD, ST_SHIFT: begin
          if (!cs_act) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else if (state_q == ST_LOAD) begin
            state_d = ST_SHIFT;
          end else if (sample_edge && (bit_cnt == len_q)) begin
            rx_push = 1'b1;
            state_d = ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign load_go    = (state_q == ST_LOAD) && (state_d == ST_SHIFT);
  assign tx_pop     = load_go & ~tx_empty;
  assign tx_word    = tx_empty ? UNDERRUN_FILL : tx_head;
  assign tx_shifted = rev_q ? (tx_sr << 1) : (tx_sr >> 1);
  assign rx_pos     = rev_q ? (len_q - bit_cnt) : bit_cnt;

  always_comb begin
    rx_next         = rx_sr;
    rx_next[rx_pos] = mosi_bit;
  end

  // A shift edge only advances MISO after a sample in the same character; this skips the
  // CPHA=1 first leading edge and the CPHA=0 trailing edge that follows a reload.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_sr         <= '0;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      len_q         <= '0;
      rev_q         <= 1'b0;
      shift_pending <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else if (state_d == ST_IDLE) begin
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      shift_pending <= 1'b0;
    end else if (load_go) begin
      tx_sr         <= tx_word;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      len_q         <= S_CHAR_LEN;
      rev_q         <= S_REV;
      shift_pending <= 1'b0;
      miso_q        <= S_REV ? tx_word[S_CHAR_LEN] : tx_word[0];
      miso_oe_q     <= 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (sample_edge) begin
        rx_sr         <= rx_next;
        bit_cnt       <= bit_cnt + 1'b1;
        shift_pending <= 1'b1;
      end else if (shift_edge && shift_pending) begin
        tx_sr         <= tx_shifted;
        shift_pending <= 1'b0;
        miso_q        <= rev_q ? tx_shifted[len_q] : tx_shifted[0];
      end
    end
  end

  // Sticky flags: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_unf_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      if (load_go && tx_empty) tx_unf_q <= 1'b1;
      else if (S_ERR_CLR)      tx_unf_q <= 1'b0;
      if (rx_push && rx_full)  rx_ovf_q <= 1'b1;
      else if (S_ERR_CLR)      rx_ovf_q <= 1'b0;
    end
  end

  spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (S_SYSCLK),
    .rst_n     (S_RESETN),
    .flush     (~S_ENABLE),
    .push      (S_TX_VALID),
    .push_data (S_TX_DATA),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (S_TX_CNT),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (S_SYSCLK),
    .rst_n     (S_RESETN),
    .flush     (~S_ENABLE),
    .push      (rx_push),
    .push_data (rx_next),
    .pop       (S_RX_READY),
    .pop_data  (rx_head),
    .count     (S_RX_CNT),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign S_SPI_MISO    = miso_q;
  assign S_SPI_MISO_OE = miso_oe_q;
  assign S_TX_READY    = ~tx_full;
  assign S_RX_DATA     = rx_head;
  assign S_RX_VALID    = ~rx_empty;
  assign S_RX_OVF      = rx_ovf_q;
  assign S_TX_UNF      = tx_unf_q;
  assign S_FRAME_DONE  = frame_done_q;
  assign S_DBG_STATE   = state_q;

endmodule

// File: tb/tb_spi_slave_fifo_ctrl.sv
// Bench for spi_slave_fifo_ctrl: a bit-level SPI master task plus a queue-based model of
// the TX/RX FIFOs and error flags; each test task checks its own results inline.
module tb_spi_slave_fifo_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int H     = 6;

  logic         S_SYSCLK = 1'b0;
  logic         S_RESETN, S_ENABLE, S_CPOL, S_CPHA, S_CSPOL, S_REV;
  logic [2:0]   S_CHAR_LEN;
  logic         S_SPI_CS, S_SPI_SCK, S_SPI_MOSI, S_SPI_MISO, S_SPI_MISO_OE;
  logic [W-1:0] S_TX_DATA, S_RX_DATA;
  logic         S_TX_VALID, S_TX_READY, S_RX_VALID, S_RX_READY;
  logic [3:0]   S_TX_CNT, S_RX_CNT;
  logic         S_ERR_CLR, S_RX_OVF, S_TX_UNF, S_FRAME_DONE;
  logic [1:0]   S_DBG_STATE;

  always #5 S_SYSCLK = ~S_SYSCLK;

  spi_slave_fifo_ctrl dut (
    .S_SYSCLK(S_SYSCLK), .S_RESETN(S_RESETN), .S_ENABLE(S_ENABLE), .S_CPOL(S_CPOL),
    .S_CPHA(S_CPHA), .S_CSPOL(S_CSPOL), .S_REV(S_REV), .S_CHAR_LEN(S_CHAR_LEN),
    .S_SPI_CS(S_SPI_CS), .S_SPI_SCK(S_SPI_SCK), .S_SPI_MOSI(S_SPI_MOSI),
    .S_SPI_MISO(S_SPI_MISO), .S_SPI_MISO_OE(S_SPI_MISO_OE), .S_TX_DATA(S_TX_DATA),
    .S_TX_VALID(S_TX_VALID), .S_TX_READY(S_TX_READY), .S_RX_DATA(S_RX_DATA),
    .S_RX_VALID(S_RX_VALID), .S_RX_READY(S_RX_READY), .S_TX_CNT(S_TX_CNT),
    .S_RX_CNT(S_RX_CNT), .S_ERR_CLR(S_ERR_CLR), .S_RX_OVF(S_RX_OVF), .S_TX_UNF(S_TX_UNF),
    .S_FRAME_DONE(S_FRAME_DONE), .S_DBG_STATE(S_DBG_STATE)
  );

  // Reference model state
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] mosi_q[$];
  logic         m_unf, m_ovf;
  int           n_tests, n_fail, fd_cnt;

  always @(negedge S_SYSCLK) if (S_FRAME_DONE === 1'b1) fd_cnt++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge S_SYSCLK); #1; end
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    S_TX_DATA = d; S_TX_VALID = 1'b1;
    tick(1);
    S_TX_VALID = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
  endtask

  task automatic clear_err();
    S_ERR_CLR = 1'b1; tick(1); S_ERR_CLR = 1'b0;
    m_unf = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic pop_rx(output logic [W-1:0] d, output logic v);
    v = S_RX_VALID; d = S_RX_DATA;
    S_RX_READY = v; tick(1); S_RX_READY = 1'b0;
  endtask

  // Master: one CS frame of n_full whole characters plus an optional partial one.
  // The target reloads after every whole character while CS is held, so n_full+1 loads occur.
  task automatic run_frame(input logic cpol, input logic cpha, input logic rev,
                           input int len, input int n_full, input int partial);
    logic [W-1:0] mask, v, word, rxw;
    int nb, pos, nchar;
    mask = '0;
    for (int i = 0; i <= len; i++) mask[i] = 1'b1;
    for (int c = 0; c <= n_full; c++) begin
      if (tx_q.size() > 0) v = tx_q.pop_front();
      else begin v = '1; m_unf = 1'b1; end
      if (c < n_full) exp_q.push_back(v & mask);
    end
    for (int c = 0; c < n_full; c++) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(mosi_q[c] & mask);
      else m_ovf = 1'b1;
    end
    got_q.delete();
    S_CPOL = cpol; S_CPHA = cpha; S_REV = rev; S_CHAR_LEN = 3'(len); S_SPI_SCK = cpol;
    tick(6);
    S_SPI_CS = ~S_CSPOL;
    tick(8);
    nchar = (partial > 0) ? n_full + 1 : n_full;
    for (int c = 0; c < nchar; c++) begin
      nb = (c < n_full) ? len + 1 : partial;
      word = mosi_q[c]; rxw = '0;
      for (int b = 0; b < nb; b++) begin
        pos = rev ? len - b : b;
        if (!cpha) begin
          S_SPI_MOSI = word[pos]; tick(H);
          rxw[pos] = S_SPI_MISO; S_SPI_SCK = ~cpol; tick(H);
          S_SPI_SCK = cpol;
        end else begin
          tick(H);
          S_SPI_SCK = ~cpol; S_SPI_MOSI = word[pos]; tick(H);
          rxw[pos] = S_SPI_MISO; S_SPI_SCK = cpol;
        end
      end
      if (c < n_full) got_q.push_back(rxw);
    end
    tick(8);
    S_SPI_CS = S_CSPOL;
    tick(8);
  endtask

  task automatic test_reset();
    n_tests++; if (S_SPI_MISO !== 1'b0)    begin n_fail++; $display("FAIL rst_miso got %b exp 0", S_SPI_MISO); end
    n_tests++; if (S_SPI_MISO_OE !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b exp 0", S_SPI_MISO_OE); end
    n_tests++; if (S_TX_READY !== 1'b1)    begin n_fail++; $display("FAIL rst_tx_ready got %b exp 1", S_TX_READY); end
    n_tests++; if (S_RX_VALID !== 1'b0)    begin n_fail++; $display("FAIL rst_rx_valid got %b exp 0", S_RX_VALID); end
    n_tests++; if (S_RX_DATA !== 8'h00)    begin n_fail++; $display("FAIL rst_rx_data got %h exp 00", S_RX_DATA); end
    n_tests++; if (S_TX_CNT !== 4'd0)      begin n_fail++; $display("FAIL rst_tx_cnt got %0d exp 0", S_TX_CNT); end
    n_tests++; if (S_RX_CNT !== 4'd0)      begin n_fail++; $display("FAIL rst_rx_cnt got %0d exp 0", S_RX_CNT); end
    n_tests++; if ({S_RX_OVF, S_TX_UNF} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b exp 00", {S_RX_OVF, S_TX_UNF}); end
    n_tests++; if (S_FRAME_DONE !== 1'b0)  begin n_fail++; $display("FAIL rst_frame_done got %b exp 0", S_FRAME_DONE); end
    n_tests++; if (S_DBG_STATE !== 2'd0)   begin n_fail++; $display("FAIL rst_state got %0d exp 0", S_DBG_STATE); end
  endtask

  task automatic test_mode0_single();
    int fd0; logic [W-1:0] d; logic v;
    push_tx(8'hA5);
    mosi_q = '{8'h3C};
    fd0 = fd_cnt;
    run_frame(1'b0, 1'b0, 1'b1, 7, 1, 0);
    n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL m0_miso got %h exp %h", got_q[0], exp_q[0]); end
    void'(exp_q.pop_front());
    n_tests++; if (S_RX_CNT !== 4'(rx_q.size())) begin n_fail++; $display("FAIL m0_rx_cnt got %0d exp %0d", S_RX_CNT, rx_q.size()); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL m0_frame_done got %0d exp 1", fd_cnt - fd0); end
    n_tests++; if (S_SPI_MISO_OE !== 1'b0) begin n_fail++; $display("FAIL m0_oe_after got %b exp 0", S_SPI_MISO_OE); end
    pop_rx(d, v);
    n_tests++; if ({v, d} !== {1'b1, rx_q.pop_front()}) begin n_fail++; $display("FAIL m0_rx_data got %b/%h exp 1/3c", v, d); end
    n_tests++; if (S_TX_UNF !== m_unf) begin n_fail++; $display("FAIL m0_unf got %b exp %b", S_TX_UNF, m_unf); end
    clear_err();
  endtask

  task automatic test_mode3_lsb_multi();
    logic [W-1:0] d; logic v;
    S_CSPOL = 1'b0; S_SPI_CS = 1'b0; tick(6);
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    mosi_q = '{8'h11, 8'h22, 8'h33};
    run_frame(1'b1, 1'b1, 1'b0, 7, 3, 0);
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (got_q[c] !== exp_q[0]) begin n_fail++; $display("FAIL m3_miso[%0d] got %h exp %h", c, got_q[c], exp_q[0]); end
      void'(exp_q.pop_front());
    end
    n_tests++; if (S_TX_CNT !== 4'd0) begin n_fail++; $display("FAIL m3_tx_cnt got %0d exp 0", S_TX_CNT); end
    n_tests++; if (S_RX_CNT !== 4'(rx_q.size())) begin n_fail++; $display("FAIL m3_rx_cnt got %0d exp %0d", S_RX_CNT, rx_q.size()); end
    while (rx_q.size() > 0) begin
      pop_rx(d, v);
      n_tests++; if ({v, d} !== {1'b1, rx_q[0]}) begin n_fail++; $display("FAIL m3_rx_data got %b/%h exp 1/%h", v, d, rx_q[0]); end
      void'(rx_q.pop_front());
    end
    S_CSPOL = 1'b1; S_SPI_CS = 1'b1; tick(6);
    clear_err();
  endtask

  task automatic test_underrun();
    logic [W-1:0] d; logic v;
    mosi_q = '{8'($urandom_range(0, 255))};
    run_frame(1'b0, 1'b0, 1'b1, 7, 1, 0);
    n_tests++; if (got_q[0] !== 8'hFF) begin n_fail++; $display("FAIL unf_miso got %h exp ff", got_q[0]); end
    void'(exp_q.pop_front());
    n_tests++; if (S_TX_UNF !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", S_TX_UNF); end
    clear_err();
    n_tests++; if (S_TX_UNF !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", S_TX_UNF); end
    pop_rx(d, v);
    n_tests++; if ({v, d} !== {1'b1, rx_q.pop_front()}) begin n_fail++; $display("FAIL unf_rx got %b/%h", v, d); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] d; logic v;
    mosi_q.delete();
    for (int i = 0; i < 9; i++) mosi_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0, 1'b1, 1'b1, 7, 9, 0);
    exp_q.delete();
    n_tests++; if (S_RX_CNT !== 4'd8) begin n_fail++; $display("FAIL ovf_rx_cnt got %0d exp 8", S_RX_CNT); end
    n_tests++; if (S_RX_OVF !== m_ovf) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", S_RX_OVF, m_ovf); end
    for (int i = 0; i < 8; i++) begin
      pop_rx(d, v);
      n_tests++; if ({v, d} !== {1'b1, rx_q[0]}) begin n_fail++; $display("FAIL ovf_rx[%0d] got %b/%h exp 1/%h", i, v, d, rx_q[0]); end
      void'(rx_q.pop_front());
    end
    n_tests++; if (S_RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b exp 0", S_RX_VALID); end
    clear_err();
  endtask

  task automatic test_abort();
    int fd0; logic [W-1:0] d; logic v;
    push_tx(8'($urandom_range(0, 255)));
    mosi_q = '{8'($urandom_range(0, 255))};
    fd0 = fd_cnt;
    run_frame(1'b0, 1'b0, 1'b1, 7, 0, 5);
    n_tests++; if (S_RX_CNT !== 4'd0) begin n_fail++; $display("FAIL abort_rx_cnt got %0d exp 0", S_RX_CNT); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL abort_frame_done got %0d exp 1", fd_cnt - fd0); end
    n_tests++; if (S_TX_CNT !== 4'(tx_q.size())) begin n_fail++; $display("FAIL abort_tx_cnt got %0d exp %0d", S_TX_CNT, tx_q.size()); end
    push_tx(8'($urandom_range(0, 255)));
    mosi_q = '{8'($urandom_range(0, 255))};
    run_frame(1'b0, 1'b0, 1'b1, 7, 1, 0);
    n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL abort_next_miso got %h exp %h", got_q[0], exp_q[0]); end
    void'(exp_q.pop_front());
    pop_rx(d, v);
    n_tests++; if ({v, d} !== {1'b1, rx_q[0]}) begin n_fail++; $display("FAIL abort_next_rx got %b/%h exp 1/%h", v, d, rx_q[0]); end
    void'(rx_q.pop_front());
    clear_err();
  endtask

  task automatic test_random_modes();
    logic [W-1:0] d; logic v; logic rev; int len;
    for (int m = 0; m < 4; m++) begin
      rev = 1'($urandom_range(0, 1));
      len = $urandom_range(3, 7);
      push_tx(8'($urandom)); push_tx(8'($urandom));
      mosi_q = '{8'($urandom), 8'($urandom)};
      run_frame(1'(m >> 1), 1'(m), rev, len, 2, 0);
      for (int c = 0; c < 2; c++) begin
        n_tests++; if (got_q[c] !== exp_q[0]) begin n_fail++; $display("FAIL rnd_m%0d_miso[%0d] got %h exp %h", m, c, got_q[c], exp_q[0]); end
        void'(exp_q.pop_front());
      end
      while (rx_q.size() > 0) begin
        pop_rx(d, v);
        n_tests++; if ({v, d} !== {1'b1, rx_q[0]}) begin n_fail++; $display("FAIL rnd_m%0d_rx got %b/%h exp 1/%h", m, v, d, rx_q[0]); end
        void'(rx_q.pop_front());
      end
      n_tests++; if (S_TX_UNF !== m_unf) begin n_fail++; $display("FAIL rnd_m%0d_unf got %b exp %b", m, S_TX_UNF, m_unf); end
      clear_err();
    end
  endtask

  task automatic test_tx_full_and_disable();
    for (int i = 0; i < 9; i++) push_tx(8'($urandom));
    n_tests++; if (S_TX_CNT !== 4'(tx_q.size())) begin n_fail++; $display("FAIL full_tx_cnt got %0d exp %0d", S_TX_CNT, tx_q.size()); end
    n_tests++; if (S_TX_READY !== 1'b0) begin n_fail++; $display("FAIL full_tx_ready got %b exp 0", S_TX_READY); end
    S_ENABLE = 1'b0; tick(2);
    tx_q.delete();
    n_tests++; if (S_TX_CNT !== 4'd0) begin n_fail++; $display("FAIL dis_tx_cnt got %0d exp 0", S_TX_CNT); end
    n_tests++; if (S_TX_READY !== 1'b1) begin n_fail++; $display("FAIL dis_tx_ready got %b exp 1", S_TX_READY); end
    S_ENABLE = 1'b1; tick(2);
  endtask

  task automatic test_mode1_len4_then_reset();
    logic [W-1:0] d; logic v;
    push_tx(8'h05);
    mosi_q = '{8'h0A};
    run_frame(1'b0, 1'b1, 1'b1, 3, 1, 0);
    n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL len4_miso got %h exp %h", got_q[0], exp_q[0]); end
    void'(exp_q.pop_front());
    pop_rx(d, v);
    n_tests++; if ({v, d} !== {1'b1, 8'h0A}) begin n_fail++; $display("FAIL len4_rx got %b/%h exp 1/0a", v, d); end
    void'(rx_q.pop_front());
    // Start another frame and reset in the middle of a character.
    push_tx(8'h3C);
    S_SPI_CS = ~S_CSPOL; tick(8);
    for (int b = 0; b < 2; b++) begin
      tick(H); S_SPI_SCK = 1'b1; S_SPI_MOSI = 1'(b); tick(H); S_SPI_SCK = 1'b0;
    end
    tick(2);
    n_tests++; if (S_SPI_MISO_OE !== 1'b1) begin n_fail++; $display("FAIL midframe_oe got %b exp 1", S_SPI_MISO_OE); end
    S_RESETN = 1'b0; #1;
    n_tests++; if ({S_SPI_MISO, S_SPI_MISO_OE, S_TX_READY, S_RX_VALID} !== 4'b0010) begin n_fail++; $display("FAIL midreset_ctl got %b exp 0010", {S_SPI_MISO, S_SPI_MISO_OE, S_TX_READY, S_RX_VALID}); end
    n_tests++; if ({S_TX_CNT, S_RX_CNT, S_RX_DATA} !== 16'h0) begin n_fail++; $display("FAIL midreset_data got %h exp 0", {S_TX_CNT, S_RX_CNT, S_RX_DATA}); end
    n_tests++; if ({S_RX_OVF, S_TX_UNF, S_FRAME_DONE, S_DBG_STATE} !== 5'b0) begin n_fail++; $display("FAIL midreset_flags got %b exp 0", {S_RX_OVF, S_TX_UNF, S_FRAME_DONE, S_DBG_STATE}); end
    S_SPI_CS = S_CSPOL; tick(4);
    S_RESETN = 1'b1; tick(4);
    tx_q.delete(); rx_q.delete(); m_unf = 1'b0; m_ovf = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; fd_cnt = 0; m_unf = 1'b0; m_ovf = 1'b0;
    S_RESETN = 1'b0; S_ENABLE = 1'b1; S_CPOL = 1'b0; S_CPHA = 1'b0; S_CSPOL = 1'b1;
    S_REV = 1'b1; S_CHAR_LEN = 3'd7; S_SPI_CS = 1'b1; S_SPI_SCK = 1'b0; S_SPI_MOSI = 1'b0;
    S_TX_DATA = '0; S_TX_VALID = 1'b0; S_RX_READY = 1'b0; S_ERR_CLR = 1'b0;
    tick(3);
    test_reset();
    S_RESETN = 1'b1; tick(4);
    test_mode0_single();
    test_mode3_lsb_multi();
    test_underrun();
    test_overflow();
    test_abort();
    test_random_modes();
    test_tx_full_and_disable();
    test_mode1_len4_then_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
